// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned WidthMin = 2;
   localparam int unsigned WidthMax = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Bits needed to count 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/carry_reg.sv
// Running-carry flop; sel=1 loads the fresh carry-in, sel=0 the computed carry.
module carry_reg (
   input  logic clock,
   input  logic reset,
   input  logic sel,
   input  logic c_in,
   input  logic c_comp,
   output logic carry
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) carry <= 1'b0;
      else        carry <= sel ? c_in : c_comp;
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder bit per cycle, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CntW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   // Holds the WIDTH-1 bits produced so far; the last bit goes straight to sum.
   logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             busy_q, done_q;
   logic             carry_q, carry_sel, carry_comp, bit_s;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_comp = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

   carry_reg u_carry_reg (
      .clock  (clock),
      .reset  (reset),
      .sel    (carry_sel),
      .c_in   (c_in),
      .c_comp (carry_comp),
      .carry  (carry_q)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_sr_d  = sum_sr_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      c_out_d   = c_out_q;
      carry_sel = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d     = ovf_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
               carry_sel = 1'b1;
               cnt_d     = '0;
               sum_sr_d  = '0;
               state_d   = StShift;
            end else begin
               state_d   = StIdle;
            end
         end
         StShift: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            sum_sr_d = (sum_sr_q >> 1) | ((WIDTH-1)'(bit_s) << (WIDTH-2));
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH-1)) begin
               state_d = StDone;
               sum_d   = {bit_s, sum_sr_q};
               c_out_d = carry_comp;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q is the carry into the MSB on this final bit.
               ovf_d   = carry_q ^ carry_comp;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         sum_sr_q <= '0;
         cnt_q    <= '0;
         sum_q    <= '0;
         c_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_sr_q <= sum_sr_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         c_out_q  <= c_out_d;
         busy_q   <= (state_d == StShift);
         done_q   <= (state_d == StDone);
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
   } exp_t;

   logic         clock, reset, start, c_in;
   logic [W-1:0] a, b;
   logic         busy, done, c_out, ovf_obs;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
   assign ovf_obs = ovf;
`else
   assign ovf_obs = 1'b0;
`endif

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_done   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
      exp_t       e;
      logic [W:0] full;
      full    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      e.sum   = full[W-1:0];
      e.c_out = full[W];
`ifdef SERIAL_ADD_OVF_EN
      e.ovf   = (ta[W-1] == tb[W-1]) && (e.sum[W-1] != ta[W-1]);
`else
      e.ovf   = 1'b0;
`endif
      return e;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clock) begin
      if (reset && done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("c_out", 32'(c_out), 32'(e.c_out));
            check("ovf", 32'(ovf_obs), 32'(e.ovf));
         end
      end
   end

   // Drive one add; poke>0 pulses start with junk operands on that negedge.
   task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int poke);
      int n;
      n = 0;
      @(negedge clock);
      a = ta; b = tb; c_in = tc; start = 1'b1;
      sb.push_back(model(ta, tb, tc));
      for (int i = 1; i <= 20 && n == 0; i++) begin
         @(negedge clock);
         if (i == 1) start = 1'b0;
         if (i == poke) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'b1; start = 1'b1;
         end else if (i == poke + 1) begin
            start = 1'b0;
         end
         if (i <= 8) begin
            check("busy_during_shift", 32'(busy), 32'd1);
            check("no_early_done", 32'(done), 32'd0);
         end
         if (done) n = i;
      end
      check("done_latency", 32'(n), 32'(W + 1));
      check("busy_at_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int   n;
      int   done_before;
      exp_t e;
      reset = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_c_out", 32'(c_out), 32'd0);
      check("rst_ovf", 32'(ovf_obs), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_add(8'h3C, 8'h15, 1'b0, 0);
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);

      run_add(8'hFF, 8'h01, 1'b0, 0);
      repeat (10) @(negedge clock);
      e = model(8'hFF, 8'h01, 1'b0);
      check("hold_sum", 32'(sum), 32'(e.sum));
      check("hold_c_out", 32'(c_out), 32'(e.c_out));
      check("hold_idle_busy", 32'(busy), 32'd0);

`ifdef SERIAL_ADD_OVF_EN
      run_add(8'h7F, 8'h01, 1'b0, 0);
      run_add(8'h80, 8'hFF, 1'b1, 0);
`endif

      // Start during SHIFT must be ignored.
      run_add(8'h5A, 8'h33, 1'b1, 4);
      repeat (12) @(negedge clock);

      // Reset in the middle of an add; nothing pushed for it.
      done_before = n_done;
      @(negedge clock);
      a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_c_out", 32'(c_out), 32'd0);
      check("mid_rst_ovf", 32'(ovf_obs), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (15) @(negedge clock);
      check("no_done_after_abort", 32'(n_done), 32'(done_before));
      run_add(8'h01, 8'h02, 1'b0, 0);

      // Back-to-back: start presented in the DONE cycle.
      run_add(8'h21, 8'h42, 1'b0, 0);
      a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
      sb.push_back(model(8'h10, 8'h20, 1'b0));
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         @(negedge clock);
         if (i == 1) begin
            start = 1'b0;
            check("b2b_no_idle", 32'(busy), 32'd1);
         end
         if (done) n = i;
      end
      check("b2b_spacing", 32'(n), 32'(W + 1));
      repeat (3) @(negedge clock);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
